// File: rtl/dtree_feature_loader_pkg.sv
// -----------------------------------------------------------------------------
// dtree_feature_loader_pkg
//
// Purpose: shared constants and types for the decision-tree feature loader.
//          Holds the frame geometry (feature count, feature width), the class
//          width, the wait-counter width, the loader FSM state encoding and
//          the mapping from frame slot index to the named tree feature.
//
// Contents:
//   FEAT_NUM  - number of feature bytes in one frame
//   FEAT_W    - width of a single feature
//   CLS_W     - width of the class returned by the tree
//   WAIT_W    - width of the class-capture wait counter (holds 1..15)
//   state_e   - loader FSM states
//   SLOT_X*   - frame slot index carrying each named feature
// -----------------------------------------------------------------------------
package dtree_feature_loader_pkg;

    localparam int FEAT_NUM = 7;
    localparam int FEAT_W   = 8;
    localparam int CLS_W    = 5;
    localparam int WAIT_W   = 4;

    // Frame order on the byte stream: X6 arrives first, X278 last.
    localparam int SLOT_X6   = 0;
    localparam int SLOT_X13  = 1;
    localparam int SLOT_X169 = 2;
    localparam int SLOT_X236 = 3;
    localparam int SLOT_X251 = 4;
    localparam int SLOT_X260 = 5;
    localparam int SLOT_X278 = 6;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DROP    = 2'd1,
        ST_EVAL    = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/dtree_feature_loader.sv
// -----------------------------------------------------------------------------
// dtree_feature_loader
//
// Purpose: collects a frame of feature bytes from a valid/ready stream into a
//          registered feature vector that feeds an external combinational
//          decision tree, waits CLS_WAIT cycles for the tree to settle, then
//          captures the tree's class and offers it on a valid/ready output.
//          Frames whose in_last marker does not line up with the final slot
//          raise a one-cycle frame_err; overlong frames are drained until
//          their in_last byte.
//
// Parameters:
//   NFEAT     - feature bytes per frame (the named outputs assume 7)
//   CLS_WAIT  - cycles between feature presentation and class capture (1..15)
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - feature byte handshake
//   in_data, in_last         - feature byte and end-of-frame marker
//   X6 .. X278               - registered features driven to the tree
//   cls_in                   - class from the tree
//   out_valid/out_ready      - result handshake
//   out_class                - captured class
//   frame_err                - one-cycle pulse on malformed frame
// -----------------------------------------------------------------------------
module dtree_feature_loader
    import dtree_feature_loader_pkg::*;
#(
    parameter int NFEAT    = FEAT_NUM,
    parameter int CLS_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic [FEAT_W-1:0] X6,
    output logic [FEAT_W-1:0] X13,
    output logic [FEAT_W-1:0] X169,
    output logic [FEAT_W-1:0] X236,
    output logic [FEAT_W-1:0] X251,
    output logic [FEAT_W-1:0] X260,
    output logic [FEAT_W-1:0] X278,
    input  logic [CLS_W-1:0]  cls_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CLS_W-1:0]  out_class,
    output logic              frame_err
);

    localparam int IDX_W = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NFEAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CLS_WAIT);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CLS_W-1:0]   class_q, class_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [FEAT_W-1:0]  feat_q [NFEAT];
    logic [NFEAT-1:0]   slot_we;
    logic               accept;
    logic               idx_at_last;

    assign in_ready    = (state_q == ST_COLLECT) || (state_q == ST_DROP);
    assign accept      = in_valid && in_ready;
    assign idx_at_last = (idx_q == IDX_LAST);

    // Next-state logic. Only COLLECT writes feature slots, so the vector
    // seen by the tree is frozen while EVAL waits and HOLD offers the class.
    // A short frame leaves untouched slots with the previous frame's bytes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        class_d = class_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        slot_we = '0;

        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    for (int i = 0; i < NFEAT; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            slot_we[i] = 1'b1;
                        end
                    end
                    if (idx_at_last) begin
                        idx_d = '0;
                        if (in_last) begin
                            wait_d  = WAIT_LOAD;
                            state_d = ST_EVAL;
                        end else begin
                            // Overlong frame: report once, then drain the rest.
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (in_last) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            ST_DROP: begin
                if (accept && in_last) begin
                    state_d = ST_COLLECT;
                end
            end

            // The counter counts down to zero and the capture happens on the
            // following edge, giving CLS_WAIT+1 cycles from last byte to valid.
            ST_EVAL: begin
                if (wait_q == '0) begin
                    class_d = cls_in;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            ST_HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_COLLECT;
                end
            end

            default: begin
                state_d = ST_COLLECT;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            idx_q   <= '0;
            wait_q  <= '0;
            class_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            class_q <= class_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Feature slot registers, one write enable per slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NFEAT; i++) begin
                feat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NFEAT; i++) begin
                if (slot_we[i]) begin
                    feat_q[i] <= in_data;
                end
            end
        end
    end

    assign X6   = feat_q[SLOT_X6];
    assign X13  = feat_q[SLOT_X13];
    assign X169 = feat_q[SLOT_X169];
    assign X236 = feat_q[SLOT_X236];
    assign X251 = feat_q[SLOT_X251];
    assign X260 = feat_q[SLOT_X260];
    assign X278 = feat_q[SLOT_X278];

    assign out_valid = valid_q;
    assign out_class = class_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_dtree_feature_loader.sv
// -----------------------------------------------------------------------------
// tb_dtree_feature_loader
//
// Directed bench for dtree_feature_loader. Instance dutA uses CLS_WAIT=1,
// instance dutB uses CLS_WAIT=4. Each instance is closed around a tree model
// that returns the low five bits of X278.
// -----------------------------------------------------------------------------
module tb_dtree_feature_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A signals
    logic       aInValid = 1'b0;
    logic       aInReady;
    logic [7:0] aInData = 8'h00;
    logic       aInLast = 1'b0;
    logic [7:0] aX6, aX13, aX169, aX236, aX251, aX260, aX278;
    logic [4:0] aClsIn;
    logic       aOutValid;
    logic       aOutReady = 1'b0;
    logic [4:0] aOutClass;
    logic       aFrameErr;

    // Instance B signals
    logic       bInValid = 1'b0;
    logic       bInReady;
    logic [7:0] bInData = 8'h00;
    logic       bInLast = 1'b0;
    logic [7:0] bX6, bX13, bX169, bX236, bX251, bX260, bX278;
    logic [4:0] bClsIn;
    logic       bOutValid;
    logic       bOutReady = 1'b0;
    logic [4:0] bOutClass;
    logic       bFrameErr;

    int checks = 0;
    int failures = 0;
    int errCountA = 0;
    int readyCount = 0;
    int latency = 0;

    always #5 clk = ~clk;

    // Tree model: class is the low five bits of X278.
    assign aClsIn = aX278[4:0];
    assign bClsIn = bX278[4:0];

    dtree_feature_loader #(.NFEAT(7), .CLS_WAIT(1)) dutA (
        .clk(clk), .rst(rst),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_last(aInLast),
        .X6(aX6), .X13(aX13), .X169(aX169), .X236(aX236), .X251(aX251), .X260(aX260), .X278(aX278),
        .cls_in(aClsIn), .out_valid(aOutValid), .out_ready(aOutReady),
        .out_class(aOutClass), .frame_err(aFrameErr)
    );

    dtree_feature_loader #(.NFEAT(7), .CLS_WAIT(4)) dutB (
        .clk(clk), .rst(rst),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_last(bInLast),
        .X6(bX6), .X13(bX13), .X169(bX169), .X236(bX236), .X251(bX251), .X260(bX260), .X278(bX278),
        .cls_in(bClsIn), .out_valid(bOutValid), .out_ready(bOutReady),
        .out_class(bOutClass), .frame_err(bFrameErr)
    );

    // Count frame_err high samples; a stuck or stretched pulse counts twice.
    always @(negedge clk) begin
        if (aFrameErr === 1'b1) errCountA++;
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One byte into A: driven at negedge, accepted at the next posedge if ready.
    task automatic applyStimulus(input logic [7:0] d, input logic last);
        @(negedge clk);
        aInValid = 1'b1;
        aInData  = d;
        aInLast  = last;
        if (aInReady === 1'b1) readyCount++;
        @(posedge clk);
        #1;
        aInValid = 1'b0;
        aInLast  = 1'b0;
    endtask

    task automatic pushB(input logic [7:0] d, input logic last);
        @(negedge clk);
        bInValid = 1'b1;
        bInData  = d;
        bInLast  = last;
        @(posedge clk);
        #1;
        bInValid = 1'b0;
        bInLast  = 1'b0;
    endtask

    // Cycles from the last-byte edge until out_valid, bounded at 20.
    task automatic waitValidA(output int cycles);
        cycles = 0;
        while (aOutValid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic waitValidB(output int cycles);
        cycles = 0;
        while (bOutValid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic releaseA();
        @(negedge clk);
        aOutReady = 1'b1;
        @(posedge clk);
        #1;
        aOutReady = 1'b0;
        checkOutput("release_valid_low", aOutValid, 1'b0);
        checkOutput("release_ready_high", aInReady, 1'b1);
    endtask

    initial begin
        // Reset state
        #2;
        checkOutput("rst_x6", aX6, 8'h00);
        checkOutput("rst_x278", aX278, 8'h00);
        checkOutput("rst_valid", aOutValid, 1'b0);
        checkOutput("rst_class", aOutClass, 5'h00);
        checkOutput("rst_err", aFrameErr, 1'b0);
        checkOutput("rst_ready", aInReady, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Clean frame 0x10..0x16, CLS_WAIT=1
        for (int i = 0; i < 7; i++) applyStimulus(8'h10 + 8'(i), (i == 6));
        checkOutput("f1_x6", aX6, 8'h10);
        checkOutput("f1_x13", aX13, 8'h11);
        checkOutput("f1_x169", aX169, 8'h12);
        checkOutput("f1_x236", aX236, 8'h13);
        checkOutput("f1_x251", aX251, 8'h14);
        checkOutput("f1_x260", aX260, 8'h15);
        checkOutput("f1_x278", aX278, 8'h16);
        checkOutput("f1_ready_eval", aInReady, 1'b0);
        waitValidA(latency);
        checkOutput("f1_latency", latency, 2);
        checkOutput("f1_class", aOutClass, 5'h16);
        checkOutput("f1_no_err", errCountA, 0);

        // Hold with out_ready low for 10 cycles, extra bytes offered
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            aInValid = 1'b1;
            aInData  = 8'hAA;
            aInLast  = 1'b1;
            checkOutput("hold_ready_low", aInReady, 1'b0);
            @(posedge clk);
            #1;
            checkOutput("hold_valid", aOutValid, 1'b1);
            checkOutput("hold_class", aOutClass, 5'h16);
            checkOutput("hold_x6", aX6, 8'h10);
        end
        aInValid = 1'b0;
        aInLast  = 1'b0;
        releaseA();

        // Short frame: 3 bytes, in_last on the 3rd
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b1);
        checkOutput("short_err_pulse", aFrameErr, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("short_err_clear", aFrameErr, 1'b0);
        checkOutput("short_err_count", errCountA, 1);
        checkOutput("short_no_valid", aOutValid, 1'b0);
        checkOutput("short_ready", aInReady, 1'b1);
        checkOutput("short_x6_new", aX6, 8'h31);
        checkOutput("short_x260_old", aX260, 8'h15);
        checkOutput("short_x278_old", aX278, 8'h16);
        for (int i = 0; i < 7; i++) applyStimulus(8'h20 + 8'(i), (i == 6));
        waitValidA(latency);
        checkOutput("f2_latency", latency, 2);
        checkOutput("f2_class", aOutClass, 5'h06);
        checkOutput("f2_x6", aX6, 8'h20);
        releaseA();

        // Long frame: 9 bytes, in_last on the 9th
        readyCount = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h40 + 8'(i), (i == 8));
            if (i == 6) checkOutput("long_err_pulse", aFrameErr, 1'b1);
            if (i == 7) checkOutput("long_err_once", aFrameErr, 1'b0);
        end
        checkOutput("long_ready_all", readyCount, 9);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("long_no_valid", aOutValid, 1'b0);
        end
        checkOutput("long_err_count", errCountA, 2);
        checkOutput("long_x6", aX6, 8'h40);
        checkOutput("long_x278", aX278, 8'h46);
        checkOutput("long_ready_after", aInReady, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(8'h50 + 8'(i), (i == 6));
        waitValidA(latency);
        checkOutput("f3_latency", latency, 2);
        checkOutput("f3_class", aOutClass, 5'h16);
        releaseA();
        for (int i = 0; i < 7; i++) applyStimulus(8'h10 + 8'(i), (i == 6));
        waitValidA(latency);
        checkOutput("f4_class_before_rst", aOutClass, 5'h16);
        releaseA();

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_x6", aX6, 8'h00);
        checkOutput("mid_rst_x278", aX278, 8'h00);
        checkOutput("mid_rst_class", aOutClass, 5'h00);
        checkOutput("mid_rst_valid", aOutValid, 1'b0);
        checkOutput("mid_rst_ready", aInReady, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(8'h01 + 8'(i), (i == 6));
        waitValidA(latency);
        checkOutput("f5_latency", latency, 2);
        checkOutput("f5_class", aOutClass, 5'h07);
        checkOutput("f5_x6", aX6, 8'h01);
        checkOutput("f5_x251", aX251, 8'h05);
        releaseA();
        checkOutput("final_err_count", errCountA, 2);

        // CLS_WAIT=4 instance: latency 5
        for (int i = 0; i < 7; i++) pushB(8'h71 + 8'(i), (i == 6));
        checkOutput("b_valid_early", bOutValid, 1'b0);
        waitValidB(latency);
        checkOutput("b_latency", latency, 5);
        checkOutput("b_class", bOutClass, 5'h17);
        checkOutput("b_x6", bX6, 8'h71);
        checkOutput("b_no_err", bFrameErr, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dtree_feature_loader.md
DTREE_FEATURE_LOADER -- requirements
Module: dtree_feature_loader

Interface
REQ-001 Parameter NFEAT, default 7: number of feature bytes per frame.
REQ-002 Parameter CLS_WAIT, default 1: cycles between feature presentation and class capture (1..15).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  feature byte valid.
REQ-006 in_ready  output  1  loader accepts byte.
REQ-007 in_data  input  8  feature byte; frame order X6, X13, X169, X236, X251, X260, X278.
REQ-008 in_last  input  1  marks final byte of frame.
REQ-009 X6, X13, X169, X236, X251, X260, X278  output  8 each  registered feature vector driven to the classifier tree.
REQ-010 cls_in  input  5  class from the combinational tree.
REQ-011 out_valid  output  1  class result valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_class  output  5  captured class.
REQ-014 frame_err  output  1  one-cycle pulse on malformed frame.

Function
REQ-015 Byte transfer occurs on a cycle with in_valid & in_ready both high; out transfer occurs on out_valid & out_ready both high.
REQ-016 FSM states: COLLECT, DROP, EVAL, HOLD; in_ready is high only in COLLECT and DROP.
REQ-017 COLLECT: an accepted byte is written to feature slot idx, where idx is a 0..NFEAT-1 counter; idx increments on acceptance.
REQ-018 COLLECT, idx=NFEAT-1, in_last=1: write slot, clear idx, load CLS_WAIT into wait counter, go EVAL.
REQ-019 COLLECT, idx<NFEAT-1, in_last=1: pulse frame_err, clear idx, stay COLLECT; feature outputs keep previous frame contents except slots already overwritten.
REQ-020 COLLECT, idx=NFEAT-1, in_last=0: write slot, pulse frame_err, clear idx, go DROP.
REQ-021 DROP: accept and discard bytes; an accepted byte with in_last=1 returns to COLLECT; no further frame_err pulses.
REQ-022 EVAL: wait counter decrements each cycle; when it reaches 0, register cls_in into out_class, assert out_valid, go HOLD.
REQ-023 With CLS_WAIT=1, out_valid rises exactly 2 cycles after the clock edge accepting the last byte.
REQ-024 HOLD: out_valid and out_class stable until transfer; on transfer deassert out_valid next cycle and go COLLECT.
REQ-025 No back-to-back overlap: the next frame is not accepted until the current result transfers.
REQ-026 Feature outputs change only on accepted bytes in COLLECT; they are stable throughout EVAL and HOLD.

Reset
REQ-027 rst asserted forces COLLECT, idx=0, wait counter=0, all feature outputs 0, out_class=0, out_valid=0, frame_err=0 immediately, independent of clk.
REQ-028 Reset mid-frame or in HOLD discards all partial frames and pending results; first byte after release goes to slot X6.

Structure
REQ-029 Shared package holds NFEAT, feature width (8), class width (5), FSM state enum, and slot index-to-feature mapping constants.
REQ-030 No sub-module required; the tree is instantiated outside, connected via X*/cls_in.

Verification
REQ-031 Bench tree model: cls_in = X278[4:0], combinational.
REQ-032 Frame 0x10..0x16 with in_last on 7th byte -> X6=0x10 ... X278=0x16, out_valid 2 cycles later, out_class=0x16, frame_err never high.
REQ-033 3 bytes with in_last on 3rd -> frame_err one-cycle pulse, no out_valid; next clean frame 0x20..0x26 -> out_class=0x06.
REQ-034 9 bytes, in_last on 9th -> frame_err pulses once after 7th byte, bytes 8-9 discarded, no out_valid, in_ready high throughout.
REQ-035 out_ready held low 10 cycles in HOLD -> out_valid/out_class stable, in_ready low, extra in_valid bytes not accepted.
REQ-036 rst pulsed after 4th byte of a frame -> all outputs 0 asynchronously; following full frame 0x01..0x07 -> out_class=0x07.
REQ-037 CLS_WAIT=4 build -> out_valid rises exactly 5 cycles after last-byte acceptance.
